// File: rtl/sap_pkg.sv
// sap_pkg: shared definitions for the SAP datapath slice.
//   - DATAW      : bus / register / RAM word width
//   - CW_*       : bit positions inside the 15-bit control word
//   - opcode_t   : instruction opcodes decoded by the Controller (IR[7:4])
package sap_pkg;

    localparam int unsigned DATAW = 8;
    localparam int unsigned CWW   = 15;

    localparam int unsigned CW_J   = 0;
    localparam int unsigned CW_CO  = 1;
    localparam int unsigned CW_CE  = 2;
    localparam int unsigned CW_OI  = 3;
    localparam int unsigned CW_BI  = 4;
    localparam int unsigned CW_SU  = 5;
    localparam int unsigned CW_SO  = 6;
    localparam int unsigned CW_AO  = 7;
    localparam int unsigned CW_AI  = 8;
    localparam int unsigned CW_II  = 9;
    localparam int unsigned CW_IO  = 10;
    localparam int unsigned CW_RO  = 11;
    localparam int unsigned CW_RI  = 12;
    localparam int unsigned CW_MI  = 13;
    localparam int unsigned CW_HLT = 14;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDA  = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_STA  = 4'h4,
        OP_LDI  = 4'h5,
        OP_JMP  = 4'h6,
        OP_JC   = 4'h7,
        OP_SHLA = 4'h8,
        OP_MULA = 4'h9,
        OP_OUT  = 4'hE,
        OP_HLT  = 4'hF
    } opcode_t;

endpackage

// File: rtl/sap_alu.sv
// sap_alu: combinational adder/subtractor for the SAP datapath.
// Ports:
//   a, b    : operands (registers A and B)
//   su      : 0 = a+b, 1 = a+~b+1 (subtract)
//   result  : low W bits of the sum (wraps)
//   carry   : bit W of the sum; for subtract, 1 means no borrow
//   zero    : result == 0
import sap_pkg::*;

module sap_alu #(
    parameter int unsigned W = DATAW
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         su,
    output logic [W-1:0] result,
    output logic         carry,
    output logic         zero
);

    logic [W:0] sum;

    always_comb begin
        sum    = {1'b0, a} + {1'b0, (su ? ~b : b)} + {{W{1'b0}}, su};
        result = sum[W-1:0];
        carry  = sum[W];
        zero   = (sum[W-1:0] == '0);
    end

endmodule

// File: rtl/sap_datapath.sv
// sap_datapath: executing half of the SAP-1 style CPU. Holds the bus, PC,
// MAR, 16-word RAM, IR, registers A/B, ALU, output register and halt latch,
// and acts on one 15-bit control word per rising clock edge.
// Ports:
//   clk         : system clock, all state changes on the rising edge
//   reset       : synchronous, active-high; clears registers, not RAM
//   ctrlwrd     : control word from the Controller (see sap_pkg CW_*)
//   instruction : IR[7:4], opcode back to the Controller
//   progwe      : program-load RAM write enable (works halted / in reset)
//   progaddr    : program-load address
//   progdata    : program-load data
//   outvalue    : output register
//   outvalid    : one-cycle strobe after outvalue is loaded
//   halted      : halt latch
//   busconflict : two or more bus drivers asserted (combinational)
//   flags       : {carry, zero}, only when SAP_FLAGS_EN is defined
// Build option: SAP_FLAGS_EN adds the flags register and port.
module sap_datapath #(
    parameter int unsigned RAMDEPTH = 16,
    parameter int unsigned DATAW    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [14:0]      ctrlwrd,
    output logic [3:0]       instruction,
    input  logic             progwe,
    input  logic [3:0]       progaddr,
    input  logic [DATAW-1:0] progdata,
    output logic [DATAW-1:0] outvalue,
    output logic             outvalid,
    output logic             halted,
    output logic             busconflict
`ifdef SAP_FLAGS_EN
    ,
    output logic [1:0]       flags
`endif
);

    import sap_pkg::*;

    logic [3:0]       pc;
    logic [3:0]       mar;
    logic [DATAW-1:0] ir;
    logic [DATAW-1:0] a;
    logic [DATAW-1:0] b;
    logic [DATAW-1:0] bus;
    logic [DATAW-1:0] ram [RAMDEPTH];

    logic [DATAW-1:0] alu_result;
    logic             alu_carry;
    logic             alu_zero;

    logic cw_j, cw_co, cw_ce, cw_oi, cw_bi, cw_su, cw_so, cw_ao;
    logic cw_ai, cw_ii, cw_io, cw_ro, cw_ri, cw_mi, cw_hlt;

    always_comb begin
        cw_j   = ctrlwrd[CW_J];
        cw_co  = ctrlwrd[CW_CO];
        cw_ce  = ctrlwrd[CW_CE];
        cw_oi  = ctrlwrd[CW_OI];
        cw_bi  = ctrlwrd[CW_BI];
        cw_su  = ctrlwrd[CW_SU];
        cw_so  = ctrlwrd[CW_SO];
        cw_ao  = ctrlwrd[CW_AO];
        cw_ai  = ctrlwrd[CW_AI];
        cw_ii  = ctrlwrd[CW_II];
        cw_io  = ctrlwrd[CW_IO];
        cw_ro  = ctrlwrd[CW_RO];
        cw_ri  = ctrlwrd[CW_RI];
        cw_mi  = ctrlwrd[CW_MI];
        cw_hlt = ctrlwrd[CW_HLT];
    end

    sap_alu #(.W(DATAW)) u_alu (
        .a      (a),
        .b      (b),
        .su     (cw_su),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    // Priority mux resolves any conflict deterministically; busconflict
    // reports it separately.
    always_comb begin
        bus = '0;
        if (cw_ro)      bus = ram[mar];
        else if (cw_io) bus = {{(DATAW-4){1'b0}}, ir[3:0]};
        else if (cw_co) bus = {{(DATAW-4){1'b0}}, pc};
        else if (cw_so) bus = alu_result;
        else if (cw_ao) bus = a;
    end

    always_comb begin
        logic [2:0] ndrv;
        ndrv = {2'b00, cw_co} + {2'b00, cw_io} + {2'b00, cw_ro}
             + {2'b00, cw_so} + {2'b00, cw_ao};
        busconflict = (ndrv > 3'd1);
    end

    assign instruction = ir[DATAW-1 -: 4];

    // Program-load port has precedence over ri and ignores halt and reset.
    always_ff @(posedge clk) begin
        if (progwe)
            ram[progaddr] <= progdata;
        else if (!reset && !halted && cw_ri)
            ram[mar] <= bus;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= '0;
            mar      <= '0;
            ir       <= '0;
            a        <= '0;
            b        <= '0;
            outvalue <= '0;
            outvalid <= 1'b0;
            halted   <= 1'b0;
        end else begin
            outvalid <= 1'b0;
            if (!halted) begin
                if (cw_mi) mar <= bus[3:0];
                if (cw_ii) ir  <= bus;
                if (cw_ai) a   <= bus;
                if (cw_bi) b   <= bus;
                if (cw_j)
                    pc <= bus[3:0];
                else if (cw_ce)
                    pc <= pc + 4'd1;
                if (cw_oi) begin
                    outvalue <= bus;
                    outvalid <= 1'b1;
                end
                if (cw_hlt) halted <= 1'b1;
            end
        end
    end

`ifdef SAP_FLAGS_EN
    always_ff @(posedge clk) begin
        if (reset)
            flags <= '0;
        else if (!halted && cw_so && cw_ai)
            flags <= {alu_carry, alu_zero};
    end
`else
    logic unused_alu_flags;
    assign unused_alu_flags = alu_carry ^ alu_zero;
`endif

endmodule

// File: tb/tb_sap_datapath.sv
// tb_sap_datapath: directed scenarios plus randomized control words checked
// against a behavioural model of the SAP datapath.
module tb_sap_datapath;

    import sap_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] ctrlwrd;
    logic [3:0]  instruction;
    logic        progwe;
    logic [3:0]  progaddr;
    logic [7:0]  progdata;
    logic [7:0]  outvalue;
    logic        outvalid;
    logic        halted;
    logic        busconflict;
`ifdef SAP_FLAGS_EN
    logic [1:0]  flags;
`endif

    sap_datapath #(.RAMDEPTH(16), .DATAW(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .ctrlwrd     (ctrlwrd),
        .instruction (instruction),
        .progwe      (progwe),
        .progaddr    (progaddr),
        .progdata    (progdata),
        .outvalue    (outvalue),
        .outvalid    (outvalid),
        .halted      (halted),
        .busconflict (busconflict)
`ifdef SAP_FLAGS_EN
        ,
        .flags       (flags)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [14:0] J   = 15'(1 << CW_J);
    localparam logic [14:0] CO  = 15'(1 << CW_CO);
    localparam logic [14:0] CE  = 15'(1 << CW_CE);
    localparam logic [14:0] OI  = 15'(1 << CW_OI);
    localparam logic [14:0] BI  = 15'(1 << CW_BI);
    localparam logic [14:0] SU  = 15'(1 << CW_SU);
    localparam logic [14:0] SO  = 15'(1 << CW_SO);
    localparam logic [14:0] AO  = 15'(1 << CW_AO);
    localparam logic [14:0] AI  = 15'(1 << CW_AI);
    localparam logic [14:0] II  = 15'(1 << CW_II);
    localparam logic [14:0] IO  = 15'(1 << CW_IO);
    localparam logic [14:0] RO  = 15'(1 << CW_RO);
    localparam logic [14:0] MI  = 15'(1 << CW_MI);
    localparam logic [14:0] HLT = 15'(1 << CW_HLT);

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [3:0] m_pc, m_mar;
    logic [7:0] m_ir, m_a, m_b, m_out;
    logic       m_ov, m_halt;
    logic [7:0] m_ram [16];
`ifdef SAP_FLAGS_EN
    logic [1:0] m_flags;
`endif

    // Sum as a plain integer: subtract is A + (256 - B)
    function automatic logic [8:0] m_alu(input logic sub);
        int s;
        s = sub ? int'(m_a) + 256 - int'(m_b) : int'(m_a) + int'(m_b);
        return s[8:0];
    endfunction

    function automatic logic [7:0] m_bus(input logic [14:0] cw);
        logic [8:0] r;
        r = m_alu(cw[CW_SU]);
        if (cw[CW_RO]) return m_ram[m_mar];
        if (cw[CW_IO]) return {4'h0, m_ir[3:0]};
        if (cw[CW_CO]) return {4'h0, m_pc};
        if (cw[CW_SO]) return r[7:0];
        if (cw[CW_AO]) return m_a;
        return 8'h00;
    endfunction

    function automatic logic m_conflict(input logic [14:0] cw);
        int n;
        n = int'(cw[CW_CO]) + int'(cw[CW_IO]) + int'(cw[CW_RO]) + int'(cw[CW_SO]) + int'(cw[CW_AO]);
        return n >= 2;
    endfunction

    task automatic drive(input logic [14:0] cw, input logic pwe = 1'b0, input logic [3:0] pa = 4'h0,
                         input logic [7:0] pd = 8'h00, input logic rst = 1'b0);
        @(negedge clk);
        ctrlwrd  = cw;
        progwe   = pwe;
        progaddr = pa;
        progdata = pd;
        reset    = rst;
        #1;
    endtask

    // Advance the model by one edge using the inputs currently driven, then
    // let the DUT take the same edge.
    task automatic tick();
        logic [7:0] bv;
        logic [8:0] r;
        logic       h;
        bv = m_bus(ctrlwrd);
        r  = m_alu(ctrlwrd[CW_SU]);
        h  = m_halt;
        if (progwe)
            m_ram[progaddr] = progdata;
        else if (!reset && !h && ctrlwrd[CW_RI])
            m_ram[m_mar] = bv;
        if (reset) begin
            m_pc = 0; m_mar = 0; m_ir = 0; m_a = 0; m_b = 0;
            m_out = 0; m_ov = 0; m_halt = 0;
`ifdef SAP_FLAGS_EN
            m_flags = 0;
`endif
        end else begin
            m_ov = 0;
            if (!h) begin
                if (ctrlwrd[CW_MI]) m_mar = bv[3:0];
                if (ctrlwrd[CW_II]) m_ir = bv;
                if (ctrlwrd[CW_AI]) m_a = bv;
                if (ctrlwrd[CW_BI]) m_b = bv;
                if (ctrlwrd[CW_J]) m_pc = bv[3:0];
                else if (ctrlwrd[CW_CE]) m_pc = 4'((int'(m_pc) + 1) % 16);
                if (ctrlwrd[CW_OI]) begin m_out = bv; m_ov = 1; end
                if (ctrlwrd[CW_HLT]) m_halt = 1;
`ifdef SAP_FLAGS_EN
                if (ctrlwrd[CW_SO] && ctrlwrd[CW_AI]) m_flags = {r[8], r[7:0] == 8'h00};
`endif
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 16; i++) begin
            drive(15'h0, 1'b1, 4'(i), 8'($urandom), 1'b1);
            tick();
        end
        checks++; if (outvalue !== 8'h00) begin errors++; $display("FAIL reset_outvalue got %h exp 00", outvalue); end
        checks++; if (outvalid !== 1'b0) begin errors++; $display("FAIL reset_outvalid got %b exp 0", outvalid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
        checks++; if (instruction !== 4'h0) begin errors++; $display("FAIL reset_instruction got %h exp 0", instruction); end
        checks++; if ({dut.pc, dut.mar, dut.a, dut.b} !== 24'h0) begin errors++; $display("FAIL reset_regs got %h exp 000000", {dut.pc, dut.mar, dut.a, dut.b}); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (dut.ram[i] !== m_ram[i]) begin errors++; $display("FAIL reset_progload[%0d] got %h exp %h", i, dut.ram[i], m_ram[i]); end
        end
    endtask

    task automatic test_fetch();
        drive(15'h0, 1'b1, 4'd0, 8'h1E); tick();
        drive(15'h0, 1'b1, 4'd14, 8'h1C); tick();
        drive(CO | MI); tick();
        drive(RO | II | CE); tick();
        checks++; if (dut.mar !== 4'd0) begin errors++; $display("FAIL fetch_mar got %h exp 0", dut.mar); end
        checks++; if (dut.ir !== 8'h1E) begin errors++; $display("FAIL fetch_ir got %h exp 1e", dut.ir); end
        checks++; if (instruction !== 4'h1) begin errors++; $display("FAIL fetch_instruction got %h exp 1", instruction); end
        checks++; if (dut.pc !== 4'd1) begin errors++; $display("FAIL fetch_pc got %h exp 1", dut.pc); end
    endtask

    task automatic test_lda();
        drive(IO | MI); tick();
        drive(RO | AI); tick();
        checks++; if (dut.mar !== 4'd14) begin errors++; $display("FAIL lda_mar got %h exp e", dut.mar); end
        checks++; if (dut.a !== 8'h1C) begin errors++; $display("FAIL lda_a got %h exp 1c", dut.a); end
    endtask

    task automatic test_alu_wrap();
        drive(15'h0, 1'b1, 4'd14, 8'hF0); tick();
        drive(RO | AI); tick();
        drive(15'h0, 1'b1, 4'd14, 8'h2F); tick();
        drive(RO | II); tick();
        drive(15'h0, 1'b1, 4'd15, 8'h20); tick();
        drive(IO | MI); tick();
        checks++; if (dut.mar !== 4'hF) begin errors++; $display("FAIL alu_mar got %h exp f", dut.mar); end
        drive(RO | BI); tick();
        drive(SO | AI); tick();
        checks++; if (dut.a !== 8'h10) begin errors++; $display("FAIL add_wrap_a got %h exp 10", dut.a); end
`ifdef SAP_FLAGS_EN
        checks++; if (flags !== 2'b10) begin errors++; $display("FAIL add_wrap_flags got %b exp 10", flags); end
`endif
        drive(SO | SU | AI); tick();
        checks++; if (dut.a !== 8'hF0) begin errors++; $display("FAIL sub_borrow_a got %h exp f0", dut.a); end
`ifdef SAP_FLAGS_EN
        checks++; if (flags !== 2'b00) begin errors++; $display("FAIL sub_borrow_flags got %b exp 00", flags); end
`endif
    endtask

    task automatic test_out_jmp();
        drive(15'h0, 1'b1, 4'd15, 8'h5A); tick();
        drive(RO | AI); tick();
        drive(AO | OI); tick();
        checks++; if (outvalue !== 8'h5A) begin errors++; $display("FAIL out_value got %h exp 5a", outvalue); end
        checks++; if (outvalid !== 1'b1) begin errors++; $display("FAIL out_strobe got %b exp 1", outvalid); end
        drive(15'h0); tick();
        checks++; if (outvalid !== 1'b0) begin errors++; $display("FAIL out_strobe_drop got %b exp 0", outvalid); end
        checks++; if (outvalue !== 8'h5A) begin errors++; $display("FAIL out_hold got %h exp 5a", outvalue); end
        drive(15'h0, 1'b1, 4'd15, 8'h63); tick();
        drive(RO | II); tick();
        checks++; if (instruction !== 4'h6) begin errors++; $display("FAIL jmp_instruction got %h exp 6", instruction); end
        drive(IO | J | CE); tick();
        checks++; if (dut.pc !== 4'd3) begin errors++; $display("FAIL jmp_over_ce_pc got %h exp 3", dut.pc); end
    endtask

    task automatic test_halt();
        drive(HLT); tick();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_latch got %b exp 1", halted); end
        drive(RO | AI | CE); tick();
        checks++; if (dut.a !== 8'h5A) begin errors++; $display("FAIL halt_a got %h exp 5a", dut.a); end
        checks++; if (dut.pc !== 4'd3) begin errors++; $display("FAIL halt_pc got %h exp 3", dut.pc); end
        drive(AO | OI); tick();
        checks++; if (outvalid !== 1'b0) begin errors++; $display("FAIL halt_outvalid got %b exp 0", outvalid); end
        drive(15'h0, 1'b1, 4'd2, 8'hAA); tick();
        checks++; if (dut.ram[2] !== 8'hAA) begin errors++; $display("FAIL halt_progload got %h exp aa", dut.ram[2]); end
        drive(15'h0, 1'b0, 4'd0, 8'h00, 1'b1); tick();
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_reset got %b exp 0", halted); end
    endtask

    task automatic test_conflict_reset();
        for (int i = 0; i < 5; i++) begin drive(CE); tick(); end
        drive(CO | AO);
        checks++; if (busconflict !== 1'b1) begin errors++; $display("FAIL conflict_flag got %b exp 1", busconflict); end
        checks++; if (dut.bus !== 8'h05) begin errors++; $display("FAIL conflict_bus got %h exp 05", dut.bus); end
        tick();
        drive(AO);
        checks++; if (busconflict !== 1'b0) begin errors++; $display("FAIL single_driver got %b exp 0", busconflict); end
        tick();
        drive(15'h0, 1'b1, 4'd0, 8'h77); tick();
        drive(RO | AI); tick();
        checks++; if (dut.a !== 8'h77) begin errors++; $display("FAIL pre_reset_a got %h exp 77", dut.a); end
        drive(SO | AI, 1'b0, 4'd0, 8'h00, 1'b1); tick();
        checks++; if (dut.a !== 8'h00) begin errors++; $display("FAIL mid_reset_a got %h exp 00", dut.a); end
        checks++; if (dut.ram[0] !== 8'h77 || dut.ram[2] !== 8'hAA) begin errors++; $display("FAIL mid_reset_ram got %h/%h exp 77/aa", dut.ram[0], dut.ram[2]); end
    endtask

    task automatic test_random();
        logic [14:0] cw;
        for (int n = 0; n < 400; n++) begin
            cw = 15'($urandom) & 15'h3FFF;
            if ($urandom_range(0, 39) == 0) cw = cw | HLT;
            drive(cw, ($urandom_range(0, 3) == 0), 4'($urandom), 8'($urandom), ($urandom_range(0, 29) == 0));
            checks++; if (busconflict !== m_conflict(cw)) begin errors++; $display("FAIL rand_conflict cw=%h got %b exp %b", cw, busconflict, m_conflict(cw)); end
            tick();
            checks++;
            if ({outvalue, outvalid, halted, instruction, dut.a, dut.b, dut.pc, dut.mar} !==
                {m_out, m_ov, m_halt, m_ir[7:4], m_a, m_b, m_pc, m_mar}) begin
                errors++;
                $display("FAIL rand_state cw=%h got out=%h v=%b h=%b op=%h a=%h b=%h pc=%h mar=%h exp out=%h v=%b h=%b op=%h a=%h b=%h pc=%h mar=%h",
                         cw, outvalue, outvalid, halted, instruction, dut.a, dut.b, dut.pc, dut.mar,
                         m_out, m_ov, m_halt, m_ir[7:4], m_a, m_b, m_pc, m_mar);
            end
`ifdef SAP_FLAGS_EN
            checks++; if (flags !== m_flags) begin errors++; $display("FAIL rand_flags got %b exp %b", flags, m_flags); end
`endif
        end
        for (int i = 0; i < 16; i++) begin
            checks++; if (dut.ram[i] !== m_ram[i]) begin errors++; $display("FAIL rand_ram[%0d] got %h exp %h", i, dut.ram[i], m_ram[i]); end
        end
    endtask

    initial begin
        ctrlwrd = '0; progwe = 1'b0; progaddr = '0; progdata = '0; reset = 1'b1;
        test_reset();
        test_fetch();
        test_lda();
        test_alu_wrap();
        test_out_jmp();
        test_halt();
        test_conflict_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
